// File: rtl/sram_arb_pkg.sv
// Shared sizing and types for the dual-port SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;

    // Identity of one of the two requesters; also used as round-robin pointer.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       contend
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    // Grant from request and pointer; pointer passes to the loser after any grant.
    always_comb begin
        gnt     = 2'b00;
        contend = 1'b0;
        ptr_d   = ptr_q;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    contend = 1'b1;
                    gnt     = (ptr_q == REQ1) ? 2'b10 : 2'b01;
                end
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                ptr_d = REQ1;
            end else if (gnt[1]) begin
                ptr_d = REQ0;
            end
        end
    end

    // Pointer register, requester 0 holds priority out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto one SRAM_1R1W; read/write ports are independent.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [1:0]        rd_gnt,
    output logic [1:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_gnt,
    output logic [ADDR_W-1:0] rdAddress,
    output logic [ADDR_W-1:0] wrAddress,
    output logic              WE,
    output logic [DATA_W-1:0] writebus,
    input  logic [DATA_W-1:0] readbus,
    output logic [CNT_W-1:0]  conflict_count
);

    logic rd_contend;
    logic wr_contend;

    logic [1:0]        rd_valid_q,  rd_valid_d;
    logic              byp_hit_q,   byp_hit_d;
    logic [DATA_W-1:0] byp_data_q,  byp_data_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CNT_W:0]    cnt_sum;

    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (rd_req),
        .gnt     (rd_gnt),
        .contend (rd_contend)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (wr_req),
        .gnt     (wr_gnt),
        .contend (wr_contend)
    );

    // Steer the granted requester onto the SRAM buses; idle buses are driven to zero.
    always_comb begin
        rdAddress = '0;
        wrAddress = '0;
        writebus  = '0;
        WE        = 1'b0;
        if (rd_gnt[0]) begin
            rdAddress = rd_addr0;
        end else if (rd_gnt[1]) begin
            rdAddress = rd_addr1;
        end
        if (wr_gnt[0]) begin
            WE        = 1'b1;
            wrAddress = wr_addr0;
            writebus  = wr_data0;
        end else if (wr_gnt[1]) begin
            WE        = 1'b1;
            wrAddress = wr_addr1;
            writebus  = wr_data1;
        end
    end

    // Next-state for read return, write-to-read bypass and the saturating conflict counter.
    always_comb begin
        rd_valid_d = rd_gnt;
        // SRAM returns the pre-write word on a same-address collision, so capture the write data.
        byp_hit_d  = (|rd_gnt) && WE && (rdAddress == wrAddress);
        byp_data_d = writebus;
        cnt_sum    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_contend} + {{CNT_W{1'b0}}, wr_contend};
        cnt_d      = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 2'b00;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
            cnt_q      <= cnt_d;
        end
    end

    // A grant followed by reset never produces a visible rd_valid.
    always_comb begin
        rd_valid = reset ? 2'b00 : rd_valid_q;
        rd_data  = '0;
        if (|rd_valid) begin
            rd_data = byp_hit_q ? byp_data_q : readbus;
        end
    end

    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM_1R1W model plus a transaction-level reference.
module tb_sram_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    rd_req = '0;
    logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0;
    logic [1:0]    rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic [1:0]    wr_req = '0;
    logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0;
    logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
    logic [1:0]    wr_gnt;
    logic [AW-1:0] rdAddress, wrAddress;
    logic          WE;
    logic [DW-1:0] writebus;
    logic [DW-1:0] readbus;
    logic [15:0]   conflict_count;

    int errors = 0;
    int checks = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock          (clock),
        .reset          (reset),
        .rd_req         (rd_req),
        .rd_addr0       (rd_addr0),
        .rd_addr1       (rd_addr1),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .wr_req         (wr_req),
        .wr_addr0       (wr_addr0),
        .wr_addr1       (wr_addr1),
        .wr_data0       (wr_data0),
        .wr_data1       (wr_data1),
        .wr_gnt         (wr_gnt),
        .rdAddress      (rdAddress),
        .wrAddress      (wrAddress),
        .WE             (WE),
        .writebus       (writebus),
        .readbus        (readbus),
        .conflict_count (conflict_count)
    );

    always #5 clock = ~clock;

    // SRAM_1R1W: registered read of the pre-write contents.
    logic [DW-1:0] sram [128];
    always @(posedge clock) begin
        if (WE) sram[wrAddress] <= writebus;
        readbus <= sram[rdAddress];
    end

    // Reference state: per-port priority owner, memory image, pending read return, counter.
    int            ptr_r = 0;
    int            ptr_w = 0;
    int            m_cnt = 0;
    logic [DW-1:0] mem_m [128];
    logic [1:0]    pend_v = 2'b00;
    logic [DW-1:0] pend_d = '0;

    function automatic logic [1:0] arb(logic [1:0] req, int ptr);
        if (req == 2'b11) return (ptr == 1) ? 2'b10 : 2'b01;
        return req;
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs at negedge, advance the model, return at posedge+1.
    task automatic cyc();
        logic [1:0]    eg_r, eg_w;
        logic [AW-1:0] ea_r, ea_w;
        logic [DW-1:0] ed_w;
        @(negedge clock);
        eg_r = reset ? 2'b00 : arb(rd_req, ptr_r);
        eg_w = reset ? 2'b00 : arb(wr_req, ptr_w);
        ea_r = eg_r[1] ? rd_addr1 : (eg_r[0] ? rd_addr0 : '0);
        ea_w = eg_w[1] ? wr_addr1 : (eg_w[0] ? wr_addr0 : '0);
        ed_w = eg_w[1] ? wr_data1 : (eg_w[0] ? wr_data0 : '0);
        chk("rd_gnt",    32'(rd_gnt),    32'(eg_r));
        chk("wr_gnt",    32'(wr_gnt),    32'(eg_w));
        chk("rdAddress", 32'(rdAddress), 32'(ea_r));
        chk("wrAddress", 32'(wrAddress), 32'(ea_w));
        chk("WE",        32'(WE),        32'(eg_w != 2'b00));
        chk("writebus",  writebus,       ed_w);
        chk("rd_valid",  32'(rd_valid),  reset ? 32'd0 : 32'(pend_v));
        chk("rd_data",   rd_data,        (reset || pend_v == 2'b00) ? 32'd0 : pend_d);
        chk("conflict_count", 32'(conflict_count), 32'(m_cnt));
        if (reset) begin
            ptr_r  = 0;
            ptr_w  = 0;
            m_cnt  = 0;
            pend_v = 2'b00;
            pend_d = '0;
        end else begin
            m_cnt = m_cnt + int'(rd_req == 2'b11) + int'(wr_req == 2'b11);
            if (m_cnt > 65535) m_cnt = 65535;
            if (eg_w != 2'b00) mem_m[ea_w] = ed_w;
            pend_v = eg_r;
            pend_d = mem_m[ea_r];
            if (eg_r != 2'b00) ptr_r = eg_r[0] ? 1 : 0;
            if (eg_w != 2'b00) ptr_w = eg_w[0] ? 1 : 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rd_req = 2'b00;
        wr_req = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_cnt",   32'(conflict_count), 32'd0);
        chk("rst_valid", 32'(rd_valid),       32'd0);
        chk("rst_data",  rd_data,             32'd0);

        // Fill the whole SRAM, alternating requesters
        for (int a = 0; a < 128; a++) begin
            wr_req   = (a % 2 == 1) ? 2'b10 : 2'b01;
            wr_addr0 = AW'(a);
            wr_addr1 = AW'(a);
            wr_data0 = (32'(a) * 32'h01010101) ^ 32'h5A5A0000;
            wr_data1 = wr_data0;
            cyc();
        end
        wr_req = 2'b01; wr_addr0 = 7'h05; wr_data0 = 32'hDEADBEEF;
        cyc();

        // Single read of DEADBEEF after reset
        do_reset();
        rd_req = 2'b01; rd_addr0 = 7'h05;
        #1 chk("t035_gnt", 32'(rd_gnt), 32'h1);
        cyc();
        idle();
        chk("t035_valid", 32'(rd_valid), 32'h1);
        chk("t035_data",  rd_data,       32'hDEADBEEF);
        cyc();

        // Held read contention alternates grants
        do_reset();
        rd_req = 2'b11; rd_addr0 = 7'h03; rd_addr1 = 7'h04;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t036_gnt", 32'(rd_gnt), (i % 2 == 1) ? 32'h2 : 32'h1);
            cyc();
        end
        idle();
        chk("t036_cnt", 32'(conflict_count), 32'd4);
        cyc();

        // Contended writes, loser keeps its request
        do_reset();
        wr_req = 2'b11;
        wr_addr0 = 7'h1C; wr_data0 = 32'h1;
        wr_addr1 = 7'h1D; wr_data1 = 32'h2;
        #1 chk("t037_we1", 32'(WE), 32'h1);
        chk("t037_wa1", 32'(wrAddress), 32'h1C);
        cyc();
        wr_req = 2'b10;
        #1 chk("t037_we2", 32'(WE), 32'h1);
        chk("t037_wa2", 32'(wrAddress), 32'h1D);
        cyc();
        idle();
        rd_req = 2'b01; rd_addr0 = 7'h1C;
        cyc();
        chk("t037_rd1C", rd_data, 32'h1);
        rd_req = 2'b10; rd_addr1 = 7'h1D;
        cyc();
        chk("t037_rd1D", rd_data, 32'h2);

        // Same-address read and write in one cycle
        rd_req = 2'b01; rd_addr0 = 7'h30;
        wr_req = 2'b10; wr_addr1 = 7'h30; wr_data1 = 32'hCAFE0001;
        cyc();
        idle();
        chk("t038_bypass", rd_data, 32'hCAFE0001);
        cyc();

        // Reset right after a read grant
        rd_req = 2'b11; rd_addr0 = 7'h11; rd_addr1 = 7'h12;
        cyc();
        reset = 1'b1;
        wr_req = 2'b11;
        #1 chk("t039_valid", 32'(rd_valid), 32'd0);
        chk("t039_rgnt", 32'(rd_gnt), 32'd0);
        chk("t039_wgnt", 32'(wr_gnt), 32'd0);
        chk("t039_we",   32'(WE),     32'd0);
        cyc();
        reset = 1'b0;
        wr_req = 2'b00;
        #1 chk("t039_ptr", 32'(rd_gnt), 32'h1);
        chk("t039_cnt", 32'(conflict_count), 32'd0);
        cyc();
        idle();

        // Random traffic with occasional resets, narrow address range to provoke bypass
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            rd_req   = 2'($urandom_range(0, 3));
            wr_req   = 2'($urandom_range(0, 3));
            rd_addr0 = AW'($urandom_range(0, 7));
            rd_addr1 = AW'($urandom_range(0, 7));
            wr_addr0 = AW'($urandom_range(0, 7));
            wr_addr1 = AW'($urandom_range(0, 7));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            cyc();
        end
        reset = 1'b0;

        // Counter saturation under sustained two-port contention
        do_reset();
        rd_req = 2'b11; wr_req = 2'b11;
        for (int i = 0; i < 32767; i++) cyc();
        chk("t040_fffe", 32'(conflict_count), 32'hFFFE);
        cyc();
        chk("t040_sat", 32'(conflict_count), 32'hFFFF);
        cyc();
        chk("t040_hold", 32'(conflict_count), 32'hFFFF);
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 7, SRAM word address width (128 words).
REQ-002 Parameter: DATA_W, default 32, SRAM data width.
REQ-003 Port: clock  in  1  single design clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: rd_req  in  2  per-requester read request; bit i = requester i.
REQ-006 Port: rd_addr0, rd_addr1  in  ADDR_W each  read address of requester 0/1.
REQ-007 Port: rd_gnt  out  2  one-hot read grant, same cycle as request.
REQ-008 Port: rd_valid  out  2  one-hot; read data valid for requester i.
REQ-009 Port: rd_data  out  DATA_W  returned read word.
REQ-010 Port: wr_req  in  2  per-requester write request.
REQ-011 Port: wr_addr0, wr_addr1  in  ADDR_W each; wr_data0, wr_data1  in  DATA_W each.
REQ-012 Port: wr_gnt  out  2  one-hot write grant, same cycle as request.
REQ-013 Port: rdAddress  out  ADDR_W; wrAddress  out  ADDR_W; WE  out  1; writebus  out  DATA_W  to SRAM_1R1W.
REQ-014 Port: readbus  in  DATA_W  from SRAM_1R1W; word for address presented on previous edge.
REQ-015 Port: conflict_count  out  16  saturating count of denied-request cycles.

Function
REQ-016 Read and write ports arbitrated independently; each grants at most one requester per cycle.
REQ-017 Grants combinational from requests and a per-port priority pointer; no grant without request.
REQ-018 Only one requester asserting a port's request: it is granted regardless of pointer.
REQ-019 Both requesting: pointer holder granted; on the edge after any grant, pointer moves to the non-granted requester (round-robin).
REQ-020 No grant on a port: pointer holds.
REQ-021 Requester holds req and address/data stable until it sees gnt; a dropped req is not remembered.
REQ-022 Read grant: rdAddress = granted address same cycle; no read grant: rdAddress = 0.
REQ-023 Write grant: WE=1, wrAddress/writebus = granted address/data same cycle; else WE=0, wrAddress=0, writebus=0.
REQ-024 rd_valid[i]=1 exactly one cycle after rd_gnt[i]; rd_data = readbus that cycle; rd_valid=0 otherwise, rd_data=0 when no rd_valid.
REQ-025 Back-to-back reads: every cycle may carry a grant; throughput one read and one write per cycle.
REQ-026 Same-cycle read grant and write grant to equal addresses: rd_data next cycle returns the written data (bypass), not stale readbus.
REQ-027 Requester may hold rd_req and wr_req simultaneously; both ports may grant it in the same cycle.
REQ-028 conflict_count increments by 1 per port per cycle with both requests active (max +2 per cycle); saturates at 16'hFFFF.

Reset
REQ-029 On reset edge: both pointers -> requester 0, rd_valid=0, rd_data=0, bypass state cleared, conflict_count=0.
REQ-030 Reset asserted the cycle after a read grant: no rd_valid issued for that grant.
REQ-031 While reset is high: rd_gnt=0, wr_gnt=0, WE=0 regardless of requests.

Structure
REQ-032 Package sram_arb_pkg holds ADDR_W/DATA_W defaults, requester-id type (2 values), and conflict counter width.
REQ-033 Sub-module rr_arb2 (2-way round-robin, req/gnt/pointer), instanced once per port.
REQ-034 Sole SRAM master in the design; the SRAM model itself is not synthesized.

Verification
REQ-035 Reset, then rd_req=2'b01, rd_addr0=7'h05, SRAM[5]=32'hDEADBEEF -> rd_gnt=01 same cycle; next cycle rd_valid=01, rd_data=32'hDEADBEEF.
REQ-036 rd_req=2'b11 held 4 cycles -> rd_gnt sequence 01,10,01,10; conflict_count=4.
REQ-037 wr_req=2'b11, wr_addr0=7'h1C/data 32'h1, wr_addr1=7'h1D/data 32'h2 -> cycle1 WE=1 wrAddress=1C, cycle2 wrAddress=1D; SRAM holds both words.
REQ-038 Same cycle read addr 7'h30 (req0) and write addr 7'h30 data 32'hCAFE0001 (req1) -> next cycle rd_data=32'hCAFE0001.
REQ-039 Read grant, then reset high next cycle -> rd_valid stays 0; pointers and conflict_count return to 0.
REQ-040 Force conflict_count to 16'hFFFE, both ports contended one cycle -> count=16'hFFFF, holds on further contention.
